// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback entry type.
package regfile_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int WB_PORTS   = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: per-source valid/ready plus address and data.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
);
    logic [WB_PORTS-1:0] req_valid;
    logic [WB_PORTS-1:0] req_ready;
    logic [ADDR_W-1:0]   req_addr0;
    logic [ADDR_W-1:0]   req_addr1;
    logic [DATA_W-1:0]   req_data0;
    logic [DATA_W-1:0]   req_data1;

    modport master (output req_valid, req_addr0, req_addr1, req_data0, req_data1,
                    input  req_ready);
    modport slave  (input  req_valid, req_addr0, req_addr1, req_data0, req_data1,
                    output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: small in-order FIFO of {addr,data} writeback entries. Exposes
// per-slot occupancy and address so the top can build the pending mask.
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_addr,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [ADDR_W-1:0]              head_addr,
    output logic [DATA_W-1:0]              head_data,
    output logic [DEPTH-1:0]               ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic [CNT_W-1:0]             count;
    logic                         do_push, do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign ent_addr  = addr_mem;

    // A slot is live when its distance from the read pointer is below the count
    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        logic [PTR_W-1:0] off;
        assign off          = PTR_W'(k) - rd_ptr;
        assign ent_valid[k] = ({1'b0, off} < count);
    end

    // Storage, pointers (wrap modulo DEPTH) and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_mem <= '0;
            data_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two writeback sources (0 = ALU, 1 = LSU), each behind its
// own FIFO, share the single registered register-file write port.
// Build option REGFILE_WB_RR_EN: round-robin on ties; otherwise port 1 always wins.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_arbiter_if.slave    bus,
    output logic                   wen,
    output logic [ADDR_W-1:0]      waddr,
    output logic [DATA_W-1:0]      wdata,
    output logic [(1<<ADDR_W)-1:0] pend_mask
);
    logic [WB_PORTS-1:0]                         full, empty, push, pop;
    logic [WB_PORTS-1:0][ADDR_W-1:0]             in_addr, head_addr;
    logic [WB_PORTS-1:0][DATA_W-1:0]             in_data, head_data;
    logic [WB_PORTS-1:0][DEPTH-1:0]              ent_valid;
    logic [WB_PORTS-1:0][DEPTH-1:0][ADDR_W-1:0]  ent_addr;
    logic                                        gnt_any, gnt_sel, both, tie_sel, last;

    assign in_addr[0] = bus.req_addr0;
    assign in_addr[1] = bus.req_addr1;
    assign in_data[0] = bus.req_data0;
    assign in_data[1] = bus.req_data1;

    // Ready looks only at fullness (never at a same-cycle pop) and is held low in reset
    assign bus.req_ready = ~full & {WB_PORTS{rst_n}};
    assign push          = bus.req_valid & bus.req_ready;

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_src
        wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[p]),
            .push_addr (in_addr[p]),
            .push_data (in_data[p]),
            .pop       (pop[p]),
            .full      (full[p]),
            .empty     (empty[p]),
            .head_addr (head_addr[p]),
            .head_data (head_data[p]),
            .ent_valid (ent_valid[p]),
            .ent_addr  (ent_addr[p])
        );
    end

    // Pick one non-empty head per cycle; only the tie-break depends on the build
    always_comb begin
        both = ~empty[0] & ~empty[1];
`ifdef REGFILE_WB_RR_EN
        tie_sel = ~last;
`else
        // Port 1 wins every tie; last is tracked but cannot change the outcome
        tie_sel = 1'b1 | last;
`endif
        gnt_any = ~empty[0] | ~empty[1];
        gnt_sel = both ? tie_sel : ~empty[1];
        pop     = '0;
        if (gnt_any)
            pop[gnt_sel] = 1'b1;
    end

    // Registered write port; r0 writes consume a grant but never raise wen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            last  <= 1'b1;
        end else if (gnt_any) begin
            wen   <= (head_addr[gnt_sel] != '0);
            waddr <= head_addr[gnt_sel];
            wdata <= head_data[gnt_sel];
            last  <= gnt_sel;
        end else begin
            wen   <= 1'b0;
        end
    end

    // Registers with a write buffered in either FIFO or sitting on the write port
    always_comb begin
        pend_mask = '0;
        for (int p = 0; p < WB_PORTS; p++)
            for (int k = 0; k < DEPTH; k++)
                if (ent_valid[p][k])
                    pend_mask[ent_addr[p][k]] = 1'b1;
        if (wen)
            pend_mask[waddr] = 1'b1;
        pend_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with a queue-based reference model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH = 2;
`ifdef REGFILE_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [7:0]  pend_mask;
    int          checks = 0;
    int          errors = 0;

    regfile_wb_arbiter_if #(.ADDR_W(REG_ADDR_W), .DATA_W(REG_DATA_W)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per source plus the write-port contents
    wb_entry_t   q0[$], q1[$];
    logic        m_wen;
    logic [2:0]  m_waddr;
    logic [15:0] m_wdata;
    bit          m_last;

    function automatic void model_reset();
        q0.delete(); q1.delete();
        m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_last = 1'b1;
    endfunction

    function automatic logic [7:0] exp_pend();
        logic [7:0] m = '0;
        foreach (q0[k]) m[q0[k].addr] = 1'b1;
        foreach (q1[k]) m[q1[k].addr] = 1'b1;
        if (m_wen) m[m_waddr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic [1:0] exp_ready();
        return {q1.size() < DEPTH, q0.size() < DEPTH};
    endfunction

    task automatic drive(input logic [1:0] v, input logic [2:0] a0, input logic [15:0] d0,
                         input logic [2:0] a1, input logic [15:0] d1);
        bus.req_valid = v;
        bus.req_addr0 = a0; bus.req_data0 = d0;
        bus.req_addr1 = a1; bus.req_data1 = d1;
    endtask

    // Advance one clock: grant from queue heads as they stood before the edge, then accept pushes
    task automatic tick();
        bit acc0, acc1;
        int g;
        wb_entry_t e;
        acc0 = rst_n && bus.req_valid[0] && (q0.size() < DEPTH);
        acc1 = rst_n && bus.req_valid[1] && (q1.size() < DEPTH);
        @(posedge clk);
        g = -1;
        if (q0.size() != 0 && q1.size() != 0) g = RR ? (m_last ? 0 : 1) : 1;
        else if (q1.size() != 0) g = 1;
        else if (q0.size() != 0) g = 0;
        e = '0;
        if (g == 0) e = q0.pop_front();
        else if (g == 1) e = q1.pop_front();
        if (g >= 0) begin
            m_wen = (e.addr != 0); m_waddr = e.addr; m_wdata = e.data; m_last = (g == 1);
        end else begin
            m_wen = 1'b0;
        end
        if (acc0) begin e.addr = bus.req_addr0; e.data = bus.req_data0; q0.push_back(e); end
        if (acc1) begin e.addr = bus.req_addr1; e.data = bus.req_data1; q1.push_back(e); end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0h want 0", wen); end
        checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr: got %0h want 0", waddr); end
        checks++; if (wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %0h want 0", wdata); end
        checks++; if (pend_mask !== 8'h0) begin errors++; $display("FAIL reset_pend: got %0h want 0", pend_mask); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %0b want 00", bus.req_ready); end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b11) begin errors++; $display("FAIL release_ready: got %0b want 11", bus.req_ready); end
    endtask

    task automatic test_single();
        drive(2'b01, 3'd5, 16'hBEEF, 3'd0, 16'h0);
        tick();
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL single_early_wen: got %0h want 0", wen); end
        checks++; if (pend_mask !== 8'h20) begin errors++; $display("FAIL single_pend_e: got %0h want 20", pend_mask); end
        tick();
        checks++; if ({wen, waddr, wdata} !== {1'b1, 3'd5, 16'hBEEF}) begin
            errors++; $display("FAIL single_write: got wen=%0h a=%0h d=%0h want 1/5/beef", wen, waddr, wdata); end
        checks++; if (pend_mask !== 8'h20) begin errors++; $display("FAIL single_pend_w: got %0h want 20", pend_mask); end
        tick();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL single_wen_drop: got %0h want 0", wen); end
        checks++; if (pend_mask !== 8'h00) begin errors++; $display("FAIL single_pend_clr: got %0h want 0", pend_mask); end
    endtask

    task automatic test_collision();
        logic [2:0] first_a;
        do_reset();
        first_a = RR ? 3'd1 : 3'd2;
        for (int r = 0; r < 2; r++) begin
            drive(2'b11, 3'd1, 16'h1111, 3'd2, 16'h2222);
            tick();
            drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
            checks++; if (pend_mask !== 8'h06) begin errors++; $display("FAIL coll_pend r%0d: got %0h want 06", r, pend_mask); end
            tick();
            if (r == 0) begin
                checks++; if ({wen, waddr} !== {1'b1, first_a}) begin
                    errors++; $display("FAIL coll_first: got wen=%0h a=%0h want 1/%0h", wen, waddr, first_a); end
            end
            checks++; if ({wen, waddr, wdata} !== {m_wen, m_waddr, m_wdata}) begin
                errors++; $display("FAIL coll_e1 r%0d: got %0h/%0h/%0h want %0h/%0h/%0h", r, wen, waddr, wdata, m_wen, m_waddr, m_wdata); end
            tick();
            checks++; if ({wen, waddr, wdata} !== {m_wen, m_waddr, m_wdata}) begin
                errors++; $display("FAIL coll_e2 r%0d: got %0h/%0h/%0h want %0h/%0h/%0h", r, wen, waddr, wdata, m_wen, m_waddr, m_wdata); end
            if (r == 0) begin
                checks++; if ({wen, waddr} !== {1'b1, 3'd3 - first_a}) begin
                    errors++; $display("FAIL coll_second: got wen=%0h a=%0h want 1/%0h", wen, waddr, 3'd3 - first_a); end
            end
            tick();
        end
    endtask

    task automatic test_priority();
        int p0_grants = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(2'b11, 3'd3, 16'hAAAA, 3'($urandom_range(4, 7)), 16'($urandom_range(0, 16'h7FFF)));
            tick();
            if (wen && wdata == 16'hAAAA) p0_grants++;
            checks++; if ({wen, waddr, wdata} !== {m_wen, m_waddr, m_wdata}) begin
                errors++; $display("FAIL prio_port c%0d: got %0h/%0h/%0h want %0h/%0h/%0h", c, wen, waddr, wdata, m_wen, m_waddr, m_wdata); end
            checks++; if (bus.req_ready !== exp_ready()) begin
                errors++; $display("FAIL prio_ready c%0d: got %0b want %0b", c, bus.req_ready, exp_ready()); end
            if (!RR && c >= 1) begin
                checks++; if (bus.req_ready[0] !== 1'b0) begin
                    errors++; $display("FAIL prio_p0_full c%0d: got %0b want 0", c, bus.req_ready[0]); end
            end
        end
        checks++;
        if (RR ? (p0_grants < 3) : (p0_grants != 0)) begin
            errors++; $display("FAIL prio_p0_grants: got %0d grants to port 0 (rr=%0d)", p0_grants, RR); end
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        repeat (5) tick();
    endtask

    task automatic test_r0_full();
        do_reset();
        drive(2'b01, 3'd0, 16'hFFFF, 3'd0, 16'h0);
        tick();
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        for (int c = 0; c < 3; c++) begin
            checks++; if ({wen, pend_mask} !== {1'b0, 8'h00}) begin
                errors++; $display("FAIL r0_drop c%0d: got wen=%0h pend=%0h want 0/00", c, wen, pend_mask); end
            tick();
        end
        checks++; if (bus.req_ready !== 2'b11) begin errors++; $display("FAIL r0_consumed: got %0b want 11", bus.req_ready); end
        // Two sources pushing every cycle outrun the one-per-cycle drain
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, 3'($urandom_range(1, 7)), 16'($urandom), 3'($urandom_range(1, 7)), 16'($urandom));
            tick();
            checks++; if (bus.req_ready !== exp_ready()) begin
                errors++; $display("FAIL full_ready c%0d: got %0b want %0b", c, bus.req_ready, exp_ready()); end
        end
        checks++; if (bus.req_ready === 2'b11) begin errors++; $display("FAIL full_reached: got %0b want one port not ready", bus.req_ready); end
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        repeat (6) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive(2'($urandom), 3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
            tick();
            checks++; if ({wen, waddr, wdata} !== {m_wen, m_waddr, m_wdata}) begin
                errors++; $display("FAIL rand_port c%0d: got %0h/%0h/%0h want %0h/%0h/%0h", c, wen, waddr, wdata, m_wen, m_waddr, m_wdata); end
            checks++; if (pend_mask !== exp_pend()) begin
                errors++; $display("FAIL rand_pend c%0d: got %0h want %0h", c, pend_mask, exp_pend()); end
            checks++; if (bus.req_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready c%0d: got %0b want %0b", c, bus.req_ready, exp_ready()); end
        end
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        repeat (6) tick();
    endtask

    task automatic test_mid_reset();
        drive(2'b11, 3'd4, 16'h4444, 3'd6, 16'h6666);
        tick();
        tick();
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL midrst_pre_wen: got %0h want 1", wen); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL midrst_wen: got %0h want 0", wen); end
        checks++; if (pend_mask !== 8'h00) begin errors++; $display("FAIL midrst_pend: got %0h want 0", pend_mask); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL midrst_ready: got %0b want 00", bus.req_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if ({wen, pend_mask} !== {1'b0, 8'h00}) begin
                errors++; $display("FAIL midrst_stale c%0d: got wen=%0h pend=%0h want 0/00", c, wen, pend_mask); end
        end
    endtask

    initial begin
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        model_reset();
        test_reset();
        test_single();
        test_collision();
        test_priority();
        test_r0_full();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 8×16 register file between two writeback sources: port 0 (ALU) and port 1 (load/store unit). Each source has its own small in-order FIFO behind a valid/ready handshake. One arbiter drains both FIFOs into a registered write port (`wen`/`waddr`/`wdata`) that drives the register file directly. The block also exports a pending-write mask so the hazard unit can stall reads of registers with writes still in flight.

## Interface
- `DEPTH`, 2: entries per source FIFO; power of two, ≥2.
- `DATA_W`, 16: register data width.
- `ADDR_W`, 3: register address width; 2^ADDR_W registers, r0 hardwired zero.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  per-source write request.
- `req_ready[1:0]`  out  2  per-source accept: FIFO count < DEPTH; forced 0 while `rst_n`=0.
- `req_addr0`, `req_addr1`  in  ADDR_W  destination register per source.
- `req_data0`, `req_data1`  in  DATA_W  write data per source.
- `wen`  out  1  register-file write enable (registered).
- `waddr`  out  ADDR_W  register-file write address (registered).
- `wdata`  out  DATA_W  register-file write data (registered).
- `pend_mask`  out  2^ADDR_W  bit i = a write to ri is buffered or on the write port; bit 0 always 0.

## Operation
- Push: `req_valid[i] & req_ready[i]` at a rising edge writes {addr,data} into FIFO i. `ready` does not depend on a same-cycle pop; a full FIFO refuses the request even when it is being drained.
- Arbitration (combinational, every cycle): among non-empty FIFO heads, pick one winner. Pop the winner at the edge. Load the output register with `wen`=(head addr≠0), `waddr`, `wdata`. If no head is valid, `wen`←0 and `waddr`/`wdata` hold.
- Writes to r0 are accepted, consume a grant, and are dropped (`wen` stays 0).
- Ordering: FIFO order is preserved within a source. Order between sources is not guaranteed. Issue logic must not have WAW to the same register in flight on both ports.
- `pend_mask`: OR of one-hot(addr) over all valid entries in both FIFOs, plus one-hot(`waddr`) when `wen`=1. Combinational from registered state.
- Grant pointer `last` (1 bit) records the port granted most recently; it updates only on a grant.

## Timing
- Request accepted at edge E → earliest `wen`=1 in the cycle after edge E+1 (2-cycle latency). The register file commits at edge E+2.
- Throughput: one write per cycle total across both sources.
- Simultaneous requests on both ports, both FIFOs empty: both are accepted at E. One is written after E+1, the other after E+2.
- Reset (asynchronous, any time, including mid-drain): FIFOs empty, pointers/counts 0, `last`=1, `wen`=0, `waddr`=0, `wdata`=0, `pend_mask`=0, `req_ready`=0. Buffered writes are discarded. `req_ready`=2'b11 in the first cycle after `rst_n` rises.
- FIFO pointer wrap: modulo DEPTH. The count is ADDR-independent and saturates at DEPTH by construction.

## Configuration
- `REGFILE_WB_RR_EN` defined: round-robin arbitration. With both heads valid, grant goes to `~last`.
- Undefined: fixed priority, port 1 (load) always wins when valid. `last` is still maintained but unused. A continuously valid port 1 can starve port 0.

## Structure
- Shared package `regfile_pkg`: `REG_ADDR_W`=3, `REG_DATA_W`=16, `NUM_REGS`=8, typedef `wb_entry_t` {addr, data}, constant `WB_PORTS`=2.
- One sub-module `wb_fifo` (parameter DEPTH; push/pop/full/empty/head, plus per-entry valid/addr outputs for `pend_mask`). It is instantiated twice; the arbiter and output register live in the top.

## Test plan
- Reset release: `rst_n` low for 3 cycles → all outputs 0 including `req_ready`; first cycle after release `req_ready`=2'b11.
- Single write: port 0 pushes r5=16'hBEEF at E → `wen`=1, `waddr`=5, `wdata`=BEEF after E+1 only. `pend_mask`=8'h20 from E until `wen` drops.
- Collision (RR build): both push at E (p0 r1=0x1111, p1 r2=0x2222) with `last`=1 → r1 written after E+1, r2 after E+2. Repeat → order alternates.
- Fixed-priority build: p1 valid every cycle, p0 one push → p0 never granted while p1 non-empty; `req_ready[0]` is 0 once full.
- r0 and full: push r0=0xFFFF → no `wen`, grant consumed. Push DEPTH+1 back-to-back on p1 with arbiter busy → `req_ready[1]`=0 at count=DEPTH.
- Mid-drain reset: assert `rst_n`=0 with 3 entries buffered → `wen` drops immediately. After release, no stale writes appear.
